pipe_generator: RTL and testbench
=================================

Name: pipe_generator

Overview:
Produces the scrolling pipe field for Flappy. It holds NUM_PIPES pipes, moves them left at a divided tick rate, and recycles each pipe off the left edge with a pseudo-random gap height. It tracks which pipe the bird currently faces and presents that pipe's left-x and gap-top-y to the collision checker, which receives X_Edge/Y_Edge and returns Lose. It also keeps the BCD score.

Parameters:
NUM_PIPES, 3, pipes in flight; fixed at 3 because the flattened buses below are 30 bits wide.
PIPE_W, 80, pipe width in pixels; must match the collision checker.
SPACING, 240, left-edge spacing between consecutive pipes.
X_START, 320, initial X of pipe 0; pipe i starts at X_START + i*SPACING.
GAP_MIN, 60, minimum gap-top Y; gap top = GAP_MIN + lfsr[7:0], so the maximum is 315.
SCROLL_DIV, 416666, Clk cycles per 1-pixel scroll step; benches use 4.

Ports:
Clk  in  1  system clock
reset  in  1  asynchronous, active-high
Start  in  1  leave Idle and begin play
Ack  in  1  leave Stop and return to Idle
Lose  in  1  level from the collision checker; freezes the field
Bird_X  in  10  bird x; must lie in (PIPE_W, X_START)
X_Edge  out  10  left edge of the current pipe (registered)
Y_Edge  out  10  gap top of the current pipe (registered)
All_X  out  30  {X2,X1,X0} for video
All_Y  out  30  {Y2,Y1,Y0} for video
Score  out  8  two BCD digits, 00..99
Scored  out  1  one-cycle pulse on each score increment
Q_Idle, Q_Run, Q_Stop  out  1 each  one-hot state flags

Behaviour:
- Reset values:
  - state = Idle; Q_Idle = 1.
  - X_i = X_START + i*SPACING, i.e. 320 / 560 / 800.
  - Y_i = 150 / 200 / 250.
  - cur = 0; Score = 0; Scored = 0; tick counter = 0; LFSR = 16'hACE1.
  - X_Edge = 320; Y_Edge = 150.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It steps every Clk in every state, so Start timing randomizes the gaps.
- States:
  - Idle: positions, cur and tick counter held at their reset values; Score holds its last value. On Start: go to Run, clear Score, zero the tick counter.
  - Run: tick counter counts 0..SCROLL_DIV-1, tick = 1 on the wrap cycle. On Lose: go to Stop.
  - Stop: all positions, cur and Score frozen. On Ack: go to Idle and reload initial positions and cur = 0.
- Lose and tick in the same cycle: Lose wins, no movement that cycle.
- Start while in Run or Stop: ignored.
- Ack while in Idle or Run: ignored.
- On each tick in Run, for every pipe i:
  - X_i > 0: X_i <= X_i - 1.
  - X_i == 0: X_i <= NUM_PIPES*SPACING - 1 (719), and Y_i <= GAP_MIN + lfsr[7:0]. This keeps spacing exact.
- Pass detection (Run only, evaluated every cycle): if X_cur + PIPE_W < Bird_X (11-bit compare, no wrap), then:
  - cur <= (cur + 1) mod 3;
  - Score <= Score + 1 in BCD: 09 -> 10, 99 -> 00;
  - Scored pulses for exactly 1 cycle.
  - At most one pass per cycle.
- Because Bird_X > PIPE_W, the current pipe is always passed before it reaches X = 0. A recycle therefore never hits the current pipe.
- X_Edge/Y_Edge: registered copies of X_cur/Y_cur, 1-cycle latency after any change to the position or to cur.
- All_X/All_Y: registered, same cycle as X_Edge.
- Q_* flags are decoded directly from the state register.
- reset mid-Run: immediate return to all reset values.

Decomposition:
- Package flappy_pkg: PIPE_W, GAP_H (100), screen constants, state encodings (QIdle, QRun, QStop). The collision checker also uses these.
- Sub-module lfsr16 (Clk, reset, q[15:0]) with the seed as a parameter.
- BCD increment stays inline.

Test Plan:
- reset, then Start with SCROLL_DIV = 4 -> X0 reads 320, 319, 318 on successive 4-cycle ticks; X_Edge follows 1 cycle later; Q_Run = 1.
- Run with Bird_X = 200 -> when X0 steps to 119, then cur = 1, Score = 01, Scored pulses once, and X_Edge = X1 the next cycle.
- Run until X0 = 0, then one more tick -> X0 = 719, and Y0 = 60 + lfsr[7:0] sampled that cycle (bench compares against a model LFSR); X1/X2 spacing stays 240.
- Lose asserted on a tick cycle -> no movement; Q_Stop = 1; positions and Score frozen for 100 cycles. Ack -> Idle with 320/560/800 and Score retained. Start -> Score = 00.
- Preload Score = 99 via 99 passes, then one more pass -> Score = 00, Scored = 1.
- reset asserted mid-Run at an arbitrary cycle -> all outputs at reset values in the same cycle; Start or Ack during reset is ignored.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants and state encodings for the Flappy pipe field and the
// collision checker that consumes its edges.
package flappy_pkg;

  localparam int PIPE_W   = 80;
  localparam int GAP_H    = 100;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    QIdle = 2'd0,
    QRun  = 2'd1,
    QStop = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Shift right every clock; feed the dropped bit back through the tap mask.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/pipe_generator.sv
// Scrolling pipe field: moves NUM_PIPES pipes left at a divided rate,
// recycles them with random gap heights, tracks the pipe the bird faces
// and keeps the two-digit BCD score.
module pipe_generator #(
  parameter int NUM_PIPES  = 3,
  parameter int PIPE_W     = flappy_pkg::PIPE_W,
  parameter int SPACING    = 240,
  parameter int X_START    = 320,
  parameter int GAP_MIN    = 60,
  parameter int SCROLL_DIV = 416666
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        Lose,
  input  logic [9:0]  Bird_X,
  output logic [9:0]  X_Edge,
  output logic [9:0]  Y_Edge,
  output logic [29:0] All_X,
  output logic [29:0] All_Y,
  output logic [7:0]  Score,
  output logic        Scored,
  output logic        Q_Idle,
  output logic        Q_Run,
  output logic        Q_Stop
);
  import flappy_pkg::*;

  localparam int               CNT_W   = $clog2(SCROLL_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCROLL_DIV - 1);
  // Recycled pipes land one full period behind so spacing stays exact.
  localparam logic [9:0]       X_WRAP  = 10'(NUM_PIPES * SPACING - 1);

  function automatic logic [9:0] x_init(input int i);
    return 10'(X_START + i * SPACING);
  endfunction

  function automatic logic [9:0] y_init(input int i);
    return 10'(150 + 50 * i);
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [9:0]        xpos [NUM_PIPES];
  logic [9:0]        ypos [NUM_PIPES];
  logic [1:0]        cur;
  logic [15:0]       lfsr_q;
  logic              lfsr_unused;
  logic [9:0]        cur_x, cur_y;
  logic [10:0]       cur_right;
  logic              run_go, tick, pass, reload, start_go;
  logic [7:0]        score_inc;

  lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only the low byte feeds the gap height.
  assign lfsr_unused = ^lfsr_q[15:8];

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= QIdle;
    else       state <= state_nxt;
  end

  // Next-state: Start leaves Idle, Lose ends Run, Ack leaves Stop.
  always_comb begin
    state_nxt = state;
    case (state)
      QIdle:   if (Start) state_nxt = QRun;
      QRun:    if (Lose)  state_nxt = QStop;
      QStop:   if (Ack)   state_nxt = QIdle;
      default:            state_nxt = QIdle;
    endcase
  end

  // One-hot flags straight from the state register.
  always_comb begin
    Q_Idle = (state == QIdle);
    Q_Run  = (state == QRun);
    Q_Stop = (state == QStop);
  end

  // Current-pipe select, pass test and BCD increment.
  always_comb begin
    cur_x = xpos[0];
    cur_y = ypos[0];
    if (cur == 2'd1) begin
      cur_x = xpos[1];
      cur_y = ypos[1];
    end else if (cur == 2'd2) begin
      cur_x = xpos[2];
      cur_y = ypos[2];
    end
    // Lose freezes the field in the very cycle it arrives.
    run_go    = (state == QRun) && !Lose;
    tick      = run_go && (cnt == CNT_MAX);
    cur_right = {1'b0, cur_x} + 11'(PIPE_W);
    pass      = run_go && (cur_right < {1'b0, Bird_X});
    reload    = (state == QStop) && Ack;
    start_go  = (state == QIdle) && Start;
    if (Score[3:0] == 4'd9) begin
      score_inc[3:0] = 4'd0;
      score_inc[7:4] = (Score[7:4] == 4'd9) ? 4'd0 : Score[7:4] + 4'd1;
    end else begin
      score_inc[3:0] = Score[3:0] + 4'd1;
      score_inc[7:4] = Score[7:4];
    end
  end

  // Scroll divider: runs only while playing, restarted on Start.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (start_go) cnt <= '0;
    else if (run_go)   cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
  end

  // Pipe positions: step left on each tick, recycle at x = 0, reload on Ack.
  always_ff @(posedge Clk or posedge reset) begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (reset || reload) begin
        xpos[i] <= x_init(i);
        ypos[i] <= y_init(i);
      end else if (tick) begin
        if (xpos[i] == 10'd0) begin
          xpos[i] <= X_WRAP;
          ypos[i] <= 10'(GAP_MIN) + {2'b00, lfsr_q[7:0]};
        end else begin
          xpos[i] <= xpos[i] - 10'd1;
        end
      end
    end
  end

  // Current-pipe index, score and score pulse.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cur    <= 2'd0;
      Score  <= 8'h00;
      Scored <= 1'b0;
    end else begin
      Scored <= pass;
      if (reload)    cur <= 2'd0;
      else if (pass) cur <= (cur == 2'(NUM_PIPES - 1)) ? 2'd0 : cur + 2'd1;
      if (start_go)  Score <= 8'h00;
      else if (pass) Score <= score_inc;
    end
  end

  // Registered views for the collision checker and video.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      X_Edge <= x_init(0);
      Y_Edge <= y_init(0);
      All_X  <= {x_init(2), x_init(1), x_init(0)};
      All_Y  <= {y_init(2), y_init(1), y_init(0)};
    end else begin
      X_Edge <= cur_x;
      Y_Edge <= cur_y;
      All_X  <= {xpos[2], xpos[1], xpos[0]};
      All_Y  <= {ypos[2], ypos[1], ypos[0]};
    end
  end

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator: one instance at SCROLL_DIV = 4 for
// scrolling/recycle/stop/reset, one at SCROLL_DIV = 1 for the score wrap.
module tb_pipe_generator;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0, Ack = 1'b0, Lose = 1'b0;
  logic [9:0]  Bird_X = 10'd200;
  logic [9:0]  X_Edge, Y_Edge;
  logic [29:0] All_X, All_Y;
  logic [7:0]  Score;
  logic        Scored, Q_Idle, Q_Run, Q_Stop;

  logic        Start2 = 1'b0, Ack2 = 1'b0, Lose2 = 1'b0;
  logic [9:0]  X_Edge2, Y_Edge2;
  logic [29:0] All_X2, All_Y2;
  logic [7:0]  Score2;
  logic        Scored2, Q_Idle2, Q_Run2, Q_Stop2;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_lfsr;
  logic [9:0]  exp_y;
  logic        hit;
  logic [7:0]  exp_bcd;

  pipe_generator #(.SCROLL_DIV(4)) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Lose(Lose),
    .Bird_X(Bird_X), .X_Edge(X_Edge), .Y_Edge(Y_Edge), .All_X(All_X),
    .All_Y(All_Y), .Score(Score), .Scored(Scored), .Q_Idle(Q_Idle),
    .Q_Run(Q_Run), .Q_Stop(Q_Stop)
  );

  pipe_generator #(.SCROLL_DIV(1)) dut2 (
    .Clk(Clk), .reset(reset), .Start(Start2), .Ack(Ack2), .Lose(Lose2),
    .Bird_X(Bird_X), .X_Edge(X_Edge2), .Y_Edge(Y_Edge2), .All_X(All_X2),
    .All_Y(All_Y2), .Score(Score2), .Scored(Scored2), .Q_Idle(Q_Idle2),
    .Q_Run(Q_Run2), .Q_Stop(Q_Stop2)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Reference LFSR stepping alongside the design.
  always @(posedge Clk or posedge reset) begin
    if (reset) model_lfsr <= 16'hACE1;
    else       model_lfsr <= lfsr_next(model_lfsr);
  end

  function automatic logic [29:0] pk(input int a, input int b, input int c);
    return {10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_x0(input logic [9:0] v, input int budget, input string tag);
    logic h;
    h = 1'b0;
    for (int n = 0; n < budget && !h; n++) begin
      @(negedge Clk);
      h = (All_X[9:0] == v);
    end
    chk(tag, {31'd0, h}, 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge Clk);
    chk("rst_q_idle", {31'd0, Q_Idle}, 32'd1);
    chk("rst_x_edge", {22'd0, X_Edge}, 32'd320);
    chk("rst_y_edge", {22'd0, Y_Edge}, 32'd150);
    chk("rst_all_x", {2'd0, All_X}, {2'd0, pk(320, 560, 800)});
    chk("rst_all_y", {2'd0, All_Y}, {2'd0, pk(150, 200, 250)});
    chk("rst_score", {24'd0, Score}, 32'd0);
    chk("rst_scored", {31'd0, Scored}, 32'd0);
    reset = 1'b0;

    // Start and first scroll steps
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk("run_flag", {31'd0, Q_Run}, 32'd1);
    chk("x0_start", {22'd0, All_X[9:0]}, 32'd320);
    repeat (4) @(negedge Clk);
    chk("x0_before_tick", {22'd0, All_X[9:0]}, 32'd320);
    @(negedge Clk);
    chk("x0_tick1", {22'd0, All_X[9:0]}, 32'd319);
    chk("xedge_tick1", {22'd0, X_Edge}, 32'd319);
    repeat (4) @(negedge Clk);
    chk("x0_tick2", {22'd0, All_X[9:0]}, 32'd318);
    chk("xedge_tick2", {22'd0, X_Edge}, 32'd318);

    // First pass at X0 = 119 with Bird_X = 200
    wait_x0(10'd119, 1000, "wait_x0_119");
    chk("pass_score", {24'd0, Score}, 32'h01);
    chk("pass_scored", {31'd0, Scored}, 32'd1);
    chk("pass_xedge_old", {22'd0, X_Edge}, 32'd119);
    @(negedge Clk);
    chk("pass_xedge_x1", {22'd0, X_Edge}, 32'd359);
    chk("pass_yedge_y1", {22'd0, Y_Edge}, 32'd200);
    chk("pass_pulse_end", {31'd0, Scored}, 32'd0);

    // Recycle of pipe 0
    wait_x0(10'd0, 1000, "wait_x0_0");
    repeat (2) @(negedge Clk);
    exp_y = 10'd60 + {2'b00, model_lfsr[7:0]};
    repeat (2) @(negedge Clk);
    chk("recycle_all_x", {2'd0, All_X}, {2'd0, pk(719, 239, 479)});
    chk("recycle_y0", {22'd0, All_Y[9:0]}, {22'd0, exp_y});
    chk("recycle_y12", {12'd0, All_Y[29:10]}, {12'd0, 10'd250, 10'd200});
    chk("recycle_xedge", {22'd0, X_Edge}, 32'd239);

    // Lose on a tick cycle, freeze, Ack, restart
    repeat (2) @(negedge Clk);
    Lose = 1'b1;
    @(negedge Clk); Lose = 1'b0;
    chk("stop_flag", {31'd0, Q_Stop}, 32'd1);
    @(negedge Clk);
    chk("lose_no_move", {2'd0, All_X}, {2'd0, pk(719, 239, 479)});
    Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (100) @(negedge Clk);
    chk("stop_frozen_x", {2'd0, All_X}, {2'd0, pk(719, 239, 479)});
    chk("stop_score", {24'd0, Score}, 32'h01);
    chk("stop_start_ignored", {31'd0, Q_Stop}, 32'd1);
    Ack = 1'b1;
    @(negedge Clk); Ack = 1'b0;
    chk("ack_idle", {31'd0, Q_Idle}, 32'd1);
    @(negedge Clk);
    chk("ack_all_x", {2'd0, All_X}, {2'd0, pk(320, 560, 800)});
    chk("ack_all_y", {2'd0, All_Y}, {2'd0, pk(150, 200, 250)});
    chk("ack_xedge", {22'd0, X_Edge}, 32'd320);
    chk("ack_score_kept", {24'd0, Score}, 32'h01);
    Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    chk("restart_score", {24'd0, Score}, 32'h00);
    chk("restart_run", {31'd0, Q_Run}, 32'd1);

    // Asynchronous reset in the middle of play
    hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      @(negedge Clk);
      hit = Scored;
    end
    chk("wait_pass2", {31'd0, hit}, 32'd1);
    repeat (5) @(negedge Clk);
    #2;
    reset = 1'b1; Start = 1'b1; Ack = 1'b1;
    #1;
    chk("arst_idle", {31'd0, Q_Idle}, 32'd1);
    chk("arst_run", {31'd0, Q_Run}, 32'd0);
    chk("arst_score", {24'd0, Score}, 32'd0);
    chk("arst_xedge", {22'd0, X_Edge}, 32'd320);
    chk("arst_yedge", {22'd0, Y_Edge}, 32'd150);
    chk("arst_all_x", {2'd0, All_X}, {2'd0, pk(320, 560, 800)});
    repeat (2) @(negedge Clk);
    Start = 1'b0; Ack = 1'b0; reset = 1'b0;
    @(negedge Clk);
    chk("arst_hold_idle", {31'd0, Q_Idle}, 32'd1);
    chk("arst_hold_x", {2'd0, All_X}, {2'd0, pk(320, 560, 800)});

    // Score through 99 and wrap on the fast instance
    @(negedge Clk); Start2 = 1'b1;
    @(negedge Clk); Start2 = 1'b0;
    chk("fast_run", {31'd0, Q_Run2}, 32'd1);
    for (int k = 1; k <= 100; k++) begin
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
        @(negedge Clk);
        hit = Scored2;
      end
      chk("fast_pass_seen", {31'd0, hit}, 32'd1);
      exp_bcd = {4'((k % 100) / 10), 4'(k % 10)};
      chk("fast_score", {24'd0, Score2}, {24'd0, exp_bcd});
      if (!hit) break;
    end
    @(negedge Clk);
    chk("wrap_pulse_end", {31'd0, Scored2}, 32'd0);
    chk("wrap_score_hold", {24'd0, Score2}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
